// File: rtl/addsub_serial_p.sv
// ---------------------------------------------------------------------------
// addsub_serial_p
//   Digit-serial adder/subtractor. Operands are latched on an accepted start
//   and consumed DIGIT bits per clock, LSB digit first, so a WIDTH-bit
//   operation takes N = WIDTH/DIGIT RUN cycles followed by one DONE cycle.
//   Subtraction is a + ~b + ~cin, so cin doubles as a borrow-in and cout
//   reads as "no borrow" in subtract mode.
//
// Handshake: start is sampled only while IDLE (busy=0, done=0); one
//   accepted start produces exactly one done pulse N+1 cycles later unless
//   rst intervenes. Starts seen during RUN or DONE are dropped.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      operation request (sampled in IDLE only)
//   sub        0 = add, 1 = subtract
//   a, b       WIDTH-bit operands
//   cin        carry-in / borrow-in
//   busy       high while digits are being processed
//   done       one-cycle pulse when result/flags update
//   result     last completed result, held until the next done
//   cout       carry out of the MSB
//   ovf        signed overflow (carry into MSB ^ carry out of MSB)
//   zero       result == 0
//   dbg_state  FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
// ---------------------------------------------------------------------------
module addsub_serial_p #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
      $error("addsub_serial_p: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_last;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_cmsb;

  assign w_last = (r_cnt == CW'(N - 1));

  // One digit of the ripple: low DIGIT bits of A and B plus the running carry.
  assign w_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};

  // Partial result shifts right; the new digit enters at the top so that
  // after N digits the LSB digit has reached bit 0.
  assign w_res_nxt = (r_res >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // Carry into the MSB: on the last digit the MSB is the top bit of the
  // digit, so it is the carry out of the lower DIGIT-1 bits of that digit.
  generate
    if (DIGIT == 1) begin : g_cmsb_bit
      assign w_cmsb = r_c;
    end else begin : g_cmsb_digit
      logic [DIGIT-1:0] w_low;
      assign w_low  = {1'b0, r_a[DIGIT-2:0]} + {1'b0, r_b[DIGIT-2:0]} + {{(DIGIT-1){1'b0}}, r_c};
      assign w_cmsb = w_low[DIGIT-1];
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= 1'b0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= sub ? ~b : b;
            r_c   <= sub ? ~cin : cin;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_res <= w_res_nxt;
          r_c   <= w_sum[DIGIT];
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_res_nxt;
            r_cout   <= w_sum[DIGIT];
            r_ovf    <= w_cmsb ^ w_sum[DIGIT];
            r_zero   <= (w_res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_addsub_serial_p.sv
module tb_addsub_serial_p;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  initial forever #5 clk = ~clk;

  logic        start = 1'b0;
  logic        sub   = 1'b0;
  logic        cin   = 1'b0;
  logic [15:0] a     = '0;
  logic [15:0] b     = '0;

  // DUT 0: 8/2 (default), 1: 8/1, 2: 8/8, 3: 16/4
  logic [3:0]  busy_v, done_v, cout_v, ovf_v, zero_v;
  logic [7:0]  res0, res1, res2;
  logic [15:0] res3;
  logic [1:0]  st0, st1, st2, st3;
  logic [15:0] res_v [4];
  assign res_v[0] = {8'h00, res0};
  assign res_v[1] = {8'h00, res1};
  assign res_v[2] = {8'h00, res2};
  assign res_v[3] = res3;

  addsub_serial_p #(.WIDTH(8), .DIGIT(2)) u_d0 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .result(res0), .cout(cout_v[0]), .ovf(ovf_v[0]),
    .zero(zero_v[0]), .dbg_state(st0));
  addsub_serial_p #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .result(res1), .cout(cout_v[1]), .ovf(ovf_v[1]),
    .zero(zero_v[1]), .dbg_state(st1));
  addsub_serial_p #(.WIDTH(8), .DIGIT(8)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .result(res2), .cout(cout_v[2]), .ovf(ovf_v[2]),
    .zero(zero_v[2]), .dbg_state(st2));
  addsub_serial_p #(.WIDTH(16), .DIGIT(4)) u_d3 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[3]), .done(done_v[3]), .result(res3), .cout(cout_v[3]), .ovf(ovf_v[3]),
    .zero(zero_v[3]), .dbg_state(st3));

  int total = 0;
  int bad   = 0;

  // Cycle (after the start edge) at which done rises, per DUT
  int exp_lat [4] = '{5, 9, 2, 5};
  int dut_w   [4] = '{8, 8, 8, 16};

  // Captured per-DUT observations of the last operation
  int          g_cyc   [4];
  int          g_busy  [4];
  int          g_ndone [4];
  logic [15:0] g_res   [4];
  logic [3:0]  g_cout, g_ovf, g_zero;

  typedef struct packed {
    logic       s;
    logic [7:0] va;
    logic [7:0] vb;
    logic       c;
    logic [7:0] r;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;
  vec_t tbl [7];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one start pulse and watch all DUTs for 14 cycles.
  task automatic run_op(input logic s, input logic [15:0] va, input logic [15:0] vb, input logic vc);
    sub = s; a = va; b = vb; cin = vc; start = 1'b1;
    for (int d = 0; d < 4; d++) begin
      g_cyc[d] = 0; g_busy[d] = 0; g_ndone[d] = 0; g_res[d] = '0;
    end
    step();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    for (int c = 1; c <= 14; c++) begin
      for (int d = 0; d < 4; d++) begin
        if (busy_v[d]) g_busy[d]++;
        if (done_v[d]) begin
          g_ndone[d]++;
          if (g_cyc[d] == 0) begin
            g_cyc[d] = c; g_res[d] = res_v[d];
            g_cout[d] = cout_v[d]; g_ovf[d] = ovf_v[d]; g_zero[d] = zero_v[d];
          end
        end
      end
      step();
    end
  endtask

  // Behavioural a +/- b model: returns {zero, ovf, cout, result[15:0]}
  function automatic logic [18:0] model(input int w, input logic s, input logic [15:0] va,
                                        input logic [15:0] vb, input logic vc);
    logic [16:0] mask, bb, sum;
    logic [15:0] r;
    logic co, ov, z;
    mask = (17'd1 << w) - 17'd1;
    bb   = {1'b0, (s ? ~vb : vb)} & mask;
    sum  = ({1'b0, va} & mask) + bb + {16'd0, (s ? ~vc : vc)};
    r    = sum[15:0] & mask[15:0];
    co   = sum[w];
    ov   = (va[w-1] == bb[w-1]) && (r[w-1] != va[w-1]);
    z    = (r == 16'd0);
    return {z, ov, co, r};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    for (int d = 0; d < 4; d++) begin
      total++;
      if ({busy_v[d], done_v[d], cout_v[d], ovf_v[d], zero_v[d]} !== 5'b0 || res_v[d] !== 16'h0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: busy=%b done=%b res=%h c=%b o=%b z=%b, want all 0",
                 d, busy_v[d], done_v[d], res_v[d], cout_v[d], ovf_v[d], zero_v[d]);
      end
    end
    total++;
    if (st0 !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", st0); end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    run_op(1'b0, 16'd100, 16'd27, 1'b0);
    total++; if (g_res[0] !== 16'd127) begin bad++; $display("FAIL add_res: got %0d want 127", g_res[0]); end
    total++; if (g_cout[0] !== 1'b0) begin bad++; $display("FAIL add_cout: got %b want 0", g_cout[0]); end
    total++; if (g_ovf[0] !== 1'b0) begin bad++; $display("FAIL add_ovf: got %b want 0", g_ovf[0]); end
    total++; if (g_zero[0] !== 1'b0) begin bad++; $display("FAIL add_zero: got %b want 0", g_zero[0]); end
    total++; if (g_cyc[0] != 5) begin bad++; $display("FAIL add_latency: got %0d want 5", g_cyc[0]); end
    total++; if (g_busy[0] != 4) begin bad++; $display("FAIL add_busy_cycles: got %0d want 4", g_busy[0]); end
    total++; if (g_ndone[0] != 1) begin bad++; $display("FAIL add_done_count: got %0d want 1", g_ndone[0]); end
    step(); step(); step();
    total++; if (res0 !== 8'd127) begin bad++; $display("FAIL add_hold: got %0d want 127", res0); end
  endtask

  task automatic test_sub();
    run_op(1'b1, 16'd5, 16'd7, 1'b0);
    total++; if (g_res[0] !== 16'h00FE) begin bad++; $display("FAIL sub_res: got %h want fe", g_res[0]); end
    total++; if (g_cout[0] !== 1'b0) begin bad++; $display("FAIL sub_cout: got %b want 0", g_cout[0]); end
    total++; if (g_ovf[0] !== 1'b0) begin bad++; $display("FAIL sub_ovf: got %b want 0", g_ovf[0]); end
    run_op(1'b1, 16'h0080, 16'h0001, 1'b0);
    total++; if (g_res[0] !== 16'h007F) begin bad++; $display("FAIL sub_ovf_res: got %h want 7f", g_res[0]); end
    total++; if (g_cout[0] !== 1'b1) begin bad++; $display("FAIL sub_ovf_cout: got %b want 1", g_cout[0]); end
    total++; if (g_ovf[0] !== 1'b1) begin bad++; $display("FAIL sub_ovf_ovf: got %b want 1", g_ovf[0]); end
  endtask

  task automatic test_flags();
    run_op(1'b0, 16'h00FF, 16'h0001, 1'b0);
    total++; if (g_res[0] !== 16'h0000) begin bad++; $display("FAIL wrap_res: got %h want 00", g_res[0]); end
    total++; if (g_cout[0] !== 1'b1) begin bad++; $display("FAIL wrap_cout: got %b want 1", g_cout[0]); end
    total++; if (g_ovf[0] !== 1'b0) begin bad++; $display("FAIL wrap_ovf: got %b want 0", g_ovf[0]); end
    total++; if (g_zero[0] !== 1'b1) begin bad++; $display("FAIL wrap_zero: got %b want 1", g_zero[0]); end
    run_op(1'b0, 16'h007F, 16'h0001, 1'b0);
    total++; if (g_res[0] !== 16'h0080) begin bad++; $display("FAIL sovf_res: got %h want 80", g_res[0]); end
    total++; if (g_ovf[0] !== 1'b1) begin bad++; $display("FAIL sovf_ovf: got %b want 1", g_ovf[0]); end
    total++; if (g_cout[0] !== 1'b0) begin bad++; $display("FAIL sovf_cout: got %b want 0", g_cout[0]); end
    total++; if (g_zero[0] !== 1'b0) begin bad++; $display("FAIL sovf_zero: got %b want 0", g_zero[0]); end
  endtask

  task automatic test_back_to_back();
    sub = 1'b0; a = 16'd10; b = 16'd3; cin = 1'b0; start = 1'b1;
    step();
    // start held high with fresh operands through RUN and DONE
    for (int c = 1; c <= 5; c++) begin
      a = 16'(200 + c); b = 16'(c); sub = 1'(c % 2);
      total++;
      if (busy_v[0] !== (c <= 4) || done_v[0] !== (c == 5)) begin
        bad++;
        $display("FAIL b2b_handshake cycle %0d: busy=%b done=%b want busy=%b done=%b",
                 c, busy_v[0], done_v[0], (c <= 4), (c == 5));
      end
      if (c == 5) begin
        total++;
        if (res0 !== 8'd13) begin bad++; $display("FAIL b2b_first_res: got %0d want 13", res0); end
      end
      step();
    end
    start = 1'b0;
    total++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || st0 !== 2'd0) begin
      bad++;
      $display("FAIL b2b_idle_after_done: busy=%b done=%b state=%0d want 0 0 0", busy_v[0], done_v[0], st0);
    end
    for (int i = 0; i < 12; i++) step();
    total++; if (res0 !== 8'd13) begin bad++; $display("FAIL b2b_no_extra_op: got %0d want 13", res0); end
    run_op(1'b1, 16'd50, 16'd20, 1'b0);
    total++; if (g_res[0] !== 16'd30) begin bad++; $display("FAIL b2b_second_res: got %0d want 30", g_res[0]); end
    total++; if (g_cyc[0] != 5) begin bad++; $display("FAIL b2b_second_latency: got %0d want 5", g_cyc[0]); end
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    sub = 1'b0; a = 16'h0033; b = 16'h0011; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();                 // second RUN cycle of dut0
    rst = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      total++;
      if ({busy_v[d], done_v[d], cout_v[d], ovf_v[d], zero_v[d]} !== 5'b0 || res_v[d] !== 16'h0) begin
        bad++;
        $display("FAIL midrun_reset dut%0d: busy=%b done=%b res=%h c=%b o=%b z=%b, want all 0",
                 d, busy_v[d], done_v[d], res_v[d], cout_v[d], ovf_v[d], zero_v[d]);
      end
    end
    step();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_v[0]) ndone++;
      step();
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL midrun_no_done: got %0d pulses want 0", ndone); end
    run_op(1'b0, 16'h0033, 16'h0011, 1'b0);
    total++; if (g_res[0] !== 16'h0044) begin bad++; $display("FAIL midrun_fresh_res: got %h want 44", g_res[0]); end
  endtask

  task automatic test_param_variants();
    logic [18:0] e;
    logic        s, vc;
    logic [15:0] va, vb;
    tbl[0] = '{1'b0, 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'd5,   8'd7,  1'b0, 8'hFE,  1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h80,  8'h01, 1'b0, 8'h7F,  1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'hFF,  8'h01, 1'b0, 8'h00,  1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h7F,  8'h01, 1'b0, 8'h80,  1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h10,  8'h20, 1'b1, 8'h31,  1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'h10,  8'h05, 1'b1, 8'h0A,  1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 17; i++) begin
      if (i < 7) begin
        s = tbl[i].s; va = {8'h00, tbl[i].va}; vb = {8'h00, tbl[i].vb}; vc = tbl[i].c;
      end else begin
        s = 1'($urandom); va = 16'($urandom); vb = 16'($urandom); vc = 1'($urandom_range(0, 1));
      end
      run_op(s, va, vb, vc);
      for (int d = 0; d < 4; d++) begin
        total++;
        if (g_cyc[d] != exp_lat[d] || g_busy[d] != exp_lat[d] - 1 || g_ndone[d] != 1) begin
          bad++;
          $display("FAIL var_timing vec%0d dut%0d: done@%0d busy=%0d pulses=%0d want done@%0d busy=%0d pulses=1",
                   i, d, g_cyc[d], g_busy[d], g_ndone[d], exp_lat[d], exp_lat[d] - 1);
        end
        if (i < 7 && d < 3) e = {tbl[i].z, tbl[i].ov, tbl[i].co, 8'h00, tbl[i].r};
        else                e = model(dut_w[d], s, va, vb, vc);
        total++;
        if ({g_zero[d], g_ovf[d], g_cout[d], g_res[d]} !== e) begin
          bad++;
          $display("FAIL var_result vec%0d dut%0d: z/o/c/res=%b%b%b/%h want %b%b%b/%h",
                   i, d, g_zero[d], g_ovf[d], g_cout[d], g_res[d], e[18], e[17], e[16], e[15:0]);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_flags();
    test_back_to_back();
    test_reset_mid_run();
    test_param_variants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
